// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator for the 16-bit register-write link.
// A single-cycle start strobe captures {rw, addr, wdata}. The controller
// then shifts the frame out MSB-first on copi under an active-low ncs, and
// collects cipo into a receive register that feeds rdata at frame completion.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   start                request strobe, accepted only while busy is low
//   rw, addr, wdata      frame fields: bit 15, bits 14:8, bits 7:0
//   busy                 high from the cycle after acceptance until back in IDLE
//   done                 one-cycle pulse in the first ncs-high cycle after a frame
//   rdata                cipo bits captured during frame bits 7:0
//   sclk, copi, ncs      SPI controller outputs (sclk idles low, ncs idles high)
//   cipo                 SPI peripheral output, sampled on sclk rising
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  input  logic       cipo
);

  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 5;

  // One shared phase counter covers the longest timed interval.
  localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]     DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]     SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0]     HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0]     IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 phase_q, phase_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [FRAME_W-1:0]   rx_q, rx_d;

  logic                 ncs_d;
  logic                 sclk_d;
  logic                 copi_d;
  logic                 busy_d;
  logic                 done_d;
  logic [DATA_W-1:0]    rdata_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
    end
  end

  // Next-state logic: phase timing, bit counting, shift registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    tx_d      = tx_q;
    rx_d      = rx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          tx_d    = {rw, addr, wdata};
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            // sclk rising: capture the peripheral's current bit.
            phase_d = 1'b1;
            rx_d    = {rx_q[FRAME_W-2:0], cipo};
          end else begin
            // sclk falling: advance copi unless the last bit just completed.
            phase_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d   = ST_HOLD;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
              tx_d      = {tx_q[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == IDLE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: next values of the output flops, derived from the next
  // state so each registered output lines up with its state cycle.
  always_comb begin
    ncs_d   = 1'b1;
    sclk_d  = 1'b0;
    copi_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rdata_d = rdata;

    busy_d = (state_d != ST_IDLE);

    if ((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD)) begin
      ncs_d  = 1'b0;
      copi_d = tx_d[FRAME_W-1];
    end

    if (state_d == ST_SHIFT) begin
      sclk_d = phase_d;
    end

    // Completion is the HOLD->GAP step; an aborted frame never reaches it.
    if ((state_q == ST_HOLD) && (state_d == ST_GAP)) begin
      done_d  = 1'b1;
      rdata_d = rx_q[DATA_W-1:0];
    end
  end

  // Output registers: every SPI and status output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs   <= 1'b1;
      sclk  <= 1'b0;
      copi  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      ncs   <= ncs_d;
      sclk  <= sclk_d;
      copi  <= copi_d;
      busy  <= busy_d;
      done  <= done_d;
      rdata <= rdata_d;
    end
  end

endmodule
